// File: rtl/piso_serializer8.sv
// piso_serializer8: parallel-in, serial-out frame serializer, MSB first.
// A load in IDLE or DONE captures PI and shifts it out over WIDTH cycles.
// The frame ends with a single DONE cycle that pulses done.
// Optional feature macro: PISO_PARITY_EN. When it is defined, one even-parity
// bit (PAR state) follows the data bits.
//
// Handshake: load is a request and has no ready. It is accepted only when the
// FSM is in IDLE or DONE. A load while busy is dropped and is not queued.
// busy=1 marks cycles where SO carries frame content. done=1 marks the single
// cycle after the last bit.
module piso_serializer8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PI,
  input  logic             load,
  output logic             SO,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef PISO_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // State, shift register and bit counter; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic. DONE accepts a load exactly like IDLE, so frames can run back to back.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          sr_d    = PI;
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^PI;
`endif
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        state_d = S_DONE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state, so SO is flop-sourced and glitch-free in practice.
  always_comb begin
    SO   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SHIFT: begin
        SO   = sr_q[WIDTH-1];
        busy = 1'b1;
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        SO   = par_q;
        busy = 1'b1;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        SO   = 1'b0;
      end
    endcase
  end

  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_piso_serializer8.sv
// tb_piso_serializer8: directed bench for piso_serializer8.
// A frame-level model builds the expected {SO,busy,done} sequence for each
// accepted load, and the bench compares against it on every negedge. Literal
// bit patterns for the listed frames are also checked, to pin the model.
// The bench honours PISO_PARITY_EN in the same way as the design.
module tb_piso_serializer8;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int PAR_CYC = 1;
`else
  localparam int PAR_CYC = 0;
`endif
  localparam int FR = W + PAR_CYC + 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] PI;
  logic         load;
  logic         SO;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;

  piso_serializer8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .PI          (PI),
    .load        (load),
    .SO          (SO),
    .busy        (busy),
    .done        (done),
    .state_dbg_o (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model. exp_q holds the {SO,busy,done} values for upcoming
  // cycles, and cur holds the value expected in the current cycle.
  logic [2:0] exp_q[$];
  logic [2:0] cur = 3'b000;
  logic       model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur      = 3'b000;
      model_ok = 1'b1;
    end else begin
      if (load && !cur[1]) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back({PI[i], 1'b1, 1'b0});
`ifdef PISO_PARITY_EN
        exp_q.push_back({^PI, 1'b1, 1'b0});
`endif
        exp_q.push_back(3'b001);
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = 3'b000;
    end
  end

  // Scoreboard: compare every cycle once the model is synchronised by reset.
  always @(negedge clk) begin
    if (model_ok) check("model {SO,busy,done}", {5'd0, SO, busy, done}, {5'd0, cur});
  end

  // Loopback: an MSB-first serial-in register fed from SO.
  logic [7:0] lb = 8'h00;
  always @(posedge clk) lb <= {lb[6:0], SO};

  // Driver: apply inputs, advance one edge, then settle 1 time unit after it.
  task automatic step(input logic l, input logic [W-1:0] p, input logic r);
    load = l;
    PI   = p;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  // Load word from IDLE or DONE and check each data bit against exp_bits.
  // inj_cycle > 0 pulses load with inj_pi during that data cycle.
  task automatic run_frame(input logic [W-1:0] word, input logic [7:0] exp_bits,
                           input int inj_cycle, input logic [W-1:0] inj_pi);
    step(1'b1, word, 1'b0);
    for (int i = 0; i < W; i++) begin
      check($sformatf("frame %h bit %0d", word, i), {6'd0, SO, busy}, {6'd0, exp_bits[7-i], 1'b1});
      if (i + 1 == inj_cycle) step(1'b1, inj_pi, 1'b0);
      else step(1'b0, word, 1'b0);
    end
    check($sformatf("loopback %h", word), lb, exp_bits);
`ifdef PISO_PARITY_EN
    check($sformatf("parity %h", word), {6'd0, SO, busy}, {6'd0, ^exp_bits, 1'b1});
    step(1'b0, word, 1'b0);
`endif
    check($sformatf("done cycle %h", word), {5'd0, SO, busy, done}, 8'b0000_0001);
  endtask

  int done_cnt;

  initial begin
    load = 1'b0;
    PI   = '0;
    rst  = 1'b1;
    repeat (3) step(1'b0, 8'h00, 1'b1);
    check("reset outputs", {5'd0, SO, busy, done}, 8'h00);
    step(1'b0, 8'h00, 1'b0);
    check("idle outputs", {5'd0, SO, busy, done}, 8'h00);

    // Basic frame: 8'h94 goes out as 1,0,0,1,0,1,0,0.
    run_frame(8'h94, 8'b1001_0100, 0, 8'h00);
    step(1'b0, 8'h00, 1'b0);
    check("idle after 94", {5'd0, SO, busy, done}, 8'h00);

    // A load during data cycle 3 is ignored, so 8'hFF is never transmitted.
    run_frame(8'hA5, 8'b1010_0101, 3, 8'hFF);
    step(1'b0, 8'h00, 1'b0);
    check("idle after A5", {5'd0, SO, busy, done}, 8'h00);

    // Reset in data cycle 4 of 8'hC3 aborts the frame with no done pulse.
    step(1'b1, 8'hC3, 1'b0);
    check("C3 bit0", {6'd0, SO, busy}, 8'b0000_0011);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("C3 cycle4 busy", {7'd0, busy}, 8'h01);
    step(1'b0, 8'h00, 1'b1);
    check("after abort", {5'd0, SO, busy, done}, 8'h00);
    done_cnt = 0;
    for (int i = 0; i < FR; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (done) done_cnt++;
    end
    check("no done after abort", done_cnt[7:0], 8'd0);
    run_frame(8'h3C, 8'b0011_1100, 0, 8'h00);

    // Load held high: frames of 8'h81 repeat with one done cycle each.
    step(1'b0, 8'h00, 1'b0);
    done_cnt = 0;
    step(1'b1, 8'h81, 1'b0);
    for (int c = 1; c <= 3 * FR; c++) begin
      if (done) done_cnt++;
      if (c == FR || c == 2 * FR || c == 3 * FR)
        check($sformatf("held load done at %0d", c), {7'd0, done}, 8'h01);
      if (c < 3 * FR) step(1'b1, 8'h81, 1'b0);
    end
    check("held load done count", done_cnt[7:0], 8'd3);
    step(1'b0, 8'h00, 1'b0);
    check("idle after held", {5'd0, SO, busy, done}, 8'h00);

    // Back-to-back frames, with the second load accepted in DONE.
    run_frame(8'h00, 8'h00, 0, 8'h00);
    run_frame(8'hFF, 8'hFF, 0, 8'h00);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
